// File: rtl/adbg_pkg.sv
// Shared debug-unit definitions: TAP state encoding, default opcodes and
// the data-register selection codes used by the TAP controller.
package adbg_pkg;

    // Standard 1149.1 state encoding, so the value on a probe matches vendor docs.
    typedef enum logic [3:0] {
        TAP_EXIT2_DR   = 4'h0,
        TAP_EXIT1_DR   = 4'h1,
        TAP_SHIFT_DR   = 4'h2,
        TAP_PAUSE_DR   = 4'h3,
        TAP_SELECT_IR  = 4'h4,
        TAP_UPDATE_DR  = 4'h5,
        TAP_CAPTURE_DR = 4'h6,
        TAP_SELECT_DR  = 4'h7,
        TAP_EXIT2_IR   = 4'h8,
        TAP_EXIT1_IR   = 4'h9,
        TAP_SHIFT_IR   = 4'hA,
        TAP_PAUSE_IR   = 4'hB,
        TAP_RUN_IDLE   = 4'hC,
        TAP_UPDATE_IR  = 4'hD,
        TAP_CAPTURE_IR = 4'hE,
        TAP_TLR        = 4'hF
    } tap_state_t;

    localparam logic [3:0]  IR_IDCODE_DEF = 4'b0010;
    localparam logic [3:0]  IR_DEBUG_DEF  = 4'b1000;
    localparam logic [3:0]  IR_SAMPLE_DEF = 4'b0001;
    localparam logic [3:0]  IR_BYPASS_DEF = 4'b1111;
    localparam logic [31:0] IDCODE_DEF    = 32'h1495_1185;

    localparam logic [1:0] DR_BYPASS = 2'd0;
    localparam logic [1:0] DR_IDCODE = 2'd1;
    localparam logic [1:0] DR_DEBUG  = 2'd2;

endpackage

// File: rtl/adbg_tap_fsm.sv
// 16-state TAP controller state machine; TMS is sampled on the rising TCK edge.
module adbg_tap_fsm
    import adbg_pkg::*;
(
    input  logic       tck_i,
    input  logic       trstn_i,
    input  logic       tms_i,
    output tap_state_t state_o
);

    tap_state_t state_q, state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            TAP_TLR:        state_d = tms_i ? TAP_TLR       : TAP_RUN_IDLE;
            TAP_RUN_IDLE:   state_d = tms_i ? TAP_SELECT_DR : TAP_RUN_IDLE;
            TAP_SELECT_DR:  state_d = tms_i ? TAP_SELECT_IR : TAP_CAPTURE_DR;
            TAP_CAPTURE_DR: state_d = tms_i ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_SHIFT_DR:   state_d = tms_i ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_EXIT1_DR:   state_d = tms_i ? TAP_UPDATE_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR:   state_d = tms_i ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
            TAP_EXIT2_DR:   state_d = tms_i ? TAP_UPDATE_DR : TAP_SHIFT_DR;
            TAP_UPDATE_DR:  state_d = tms_i ? TAP_SELECT_DR : TAP_RUN_IDLE;
            TAP_SELECT_IR:  state_d = tms_i ? TAP_TLR       : TAP_CAPTURE_IR;
            TAP_CAPTURE_IR: state_d = tms_i ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_SHIFT_IR:   state_d = tms_i ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_EXIT1_IR:   state_d = tms_i ? TAP_UPDATE_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR:   state_d = tms_i ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
            TAP_EXIT2_IR:   state_d = tms_i ? TAP_UPDATE_IR : TAP_SHIFT_IR;
            TAP_UPDATE_IR:  state_d = tms_i ? TAP_SELECT_DR : TAP_RUN_IDLE;
            default:        state_d = TAP_TLR;
        endcase
    end

    always_ff @(posedge tck_i or negedge trstn_i) begin
        if (!trstn_i) state_q <= TAP_TLR;
        else          state_q <= state_d;
    end

    assign state_o = state_q;

endmodule

// File: rtl/adbg_tap_ctrl.sv
// JTAG TAP controller for the debug unit: instruction register, IDCODE and
// BYPASS data registers, state strobes and the negedge-registered TDO mux.
module adbg_tap_ctrl
    import adbg_pkg::*;
#(
    parameter int                IR_LEN       = 4,
    parameter logic [31:0]       IDCODE_VALUE = IDCODE_DEF,
    parameter logic [IR_LEN-1:0] IR_IDCODE    = IR_LEN'(IR_IDCODE_DEF),
    parameter logic [IR_LEN-1:0] IR_DEBUG     = IR_LEN'(IR_DEBUG_DEF),
    parameter logic [IR_LEN-1:0] IR_SAMPLE    = IR_LEN'(IR_SAMPLE_DEF),
    parameter logic [IR_LEN-1:0] IR_BYPASS    = '1
) (
    input  logic tck_i,
    input  logic trstn_i,
    input  logic tms_i,
    input  logic tdi_i,
    output logic tdo_o,
    output logic tdo_oe_o,
    input  logic debug_tdo_i,
    output logic test_logic_reset_o,
    output logic capture_dr_o,
    output logic shift_dr_o,
    output logic pause_dr_o,
    output logic update_dr_o,
    output logic debug_select_o
);

    tap_state_t        state;
    logic [IR_LEN-1:0] ir_q, ir_d, ir_sr_q, ir_sr_d;
    logic [31:0]       idcode_q, idcode_d;
    logic              bypass_q, bypass_d;
    logic              tdo_q, tdo_d, tdo_oe_q, tdo_oe_d;
    logic [1:0]        dr_sel;

    adbg_tap_fsm u_fsm (
        .tck_i   (tck_i),
        .trstn_i (trstn_i),
        .tms_i   (tms_i),
        .state_o (state)
    );

    // No boundary-scan chain exists here, so SAMPLE/PRELOAD runs as BYPASS.
    always_comb begin
        dr_sel = DR_BYPASS;
        if (ir_q == IR_IDCODE)                              dr_sel = DR_IDCODE;
        else if (ir_q == IR_DEBUG)                          dr_sel = DR_DEBUG;
        else if ((ir_q == IR_SAMPLE) || (ir_q == IR_BYPASS)) dr_sel = DR_BYPASS;
    end

    always_comb begin
        ir_d     = ir_q;
        ir_sr_d  = ir_sr_q;
        idcode_d = idcode_q;
        bypass_d = bypass_q;
        case (state)
            TAP_TLR:        ir_d    = IR_IDCODE;
            TAP_CAPTURE_IR: ir_sr_d = IR_LEN'(1);
            TAP_SHIFT_IR:   ir_sr_d = {tdi_i, ir_sr_q[IR_LEN-1:1]};
            TAP_UPDATE_IR:  ir_d    = ir_sr_q;
            TAP_CAPTURE_DR: begin
                bypass_d = 1'b0;
                if (dr_sel == DR_IDCODE) idcode_d = IDCODE_VALUE;
            end
            TAP_SHIFT_DR: begin
                bypass_d = tdi_i;
                if (dr_sel == DR_IDCODE) idcode_d = {tdi_i, idcode_q[31:1]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            ir_q     <= IR_IDCODE;
            ir_sr_q  <= '0;
            idcode_q <= IDCODE_VALUE;
            bypass_q <= 1'b0;
        end else begin
            ir_q     <= ir_d;
            ir_sr_q  <= ir_sr_d;
            idcode_q <= idcode_d;
            bypass_q <= bypass_d;
        end
    end

    // TDO changes on the falling edge so the probe samples it on the next rising edge.
    always_comb begin
        tdo_d    = 1'b0;
        tdo_oe_d = 1'b0;
        if (state == TAP_SHIFT_IR) begin
            tdo_d    = ir_sr_q[0];
            tdo_oe_d = 1'b1;
        end else if (state == TAP_SHIFT_DR) begin
            tdo_oe_d = 1'b1;
            case (dr_sel)
                DR_IDCODE: tdo_d = idcode_q[0];
                DR_DEBUG:  tdo_d = debug_tdo_i;
                default:   tdo_d = bypass_q;
            endcase
        end
    end

    always_ff @(negedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            tdo_q    <= 1'b0;
            tdo_oe_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_oe_q <= tdo_oe_d;
        end
    end

    assign tdo_o              = tdo_q;
    assign tdo_oe_o           = tdo_oe_q;
    assign test_logic_reset_o = (state == TAP_TLR);
    assign capture_dr_o       = (state == TAP_CAPTURE_DR);
    assign shift_dr_o         = (state == TAP_SHIFT_DR);
    assign pause_dr_o         = (state == TAP_PAUSE_DR);
    assign update_dr_o        = (state == TAP_UPDATE_DR);
    assign debug_select_o     = (ir_q == IR_DEBUG);

endmodule

// File: tb/tb_adbg_tap_ctrl.sv
// Testbench for adbg_tap_ctrl: TMS walk table, IDCODE/IR/BYPASS/DEBUG scans,
// soft reset and asynchronous reset in the middle of scans.
module tb_adbg_tap_ctrl;

    localparam int W = 8;
    // Expected vector: {tlr, capture, shift, pause, update, debug_select, tdo_oe, tdo}
    localparam logic [W-1:0] E_IDLE = 8'b0000_0000;
    localparam logic [W-1:0] E_TLR  = 8'b1000_0000;
    localparam logic [W-1:0] E_CAP  = 8'b0100_0000;
    localparam logic [W-1:0] E_PAU  = 8'b0001_0000;
    localparam logic [W-1:0] E_UPD  = 8'b0000_1000;
    localparam logic [31:0]  IDC    = 32'h1495_1185;

    logic tck   = 1'b0;
    logic trstn = 1'b1;
    logic tms   = 1'b1;
    logic tdi   = 1'b0;
    logic dtdo  = 1'b0;
    logic tdo, tdo_oe, tlr, cap, sh, pau, upd, dsel;

    adbg_tap_ctrl dut (
        .tck_i              (tck),
        .trstn_i            (trstn),
        .tms_i              (tms),
        .tdi_i              (tdi),
        .tdo_o              (tdo),
        .tdo_oe_o           (tdo_oe),
        .debug_tdo_i        (dtdo),
        .test_logic_reset_o (tlr),
        .capture_dr_o       (cap),
        .shift_dr_o         (sh),
        .pause_dr_o         (pau),
        .update_dr_o        (upd),
        .debug_select_o     (dsel)
    );

    always #5 tck = ~tck;

    typedef struct {
        logic         tms;
        logic         tdi;
        logic [W-1:0] exp;
    } vec_t;

    vec_t         vecs[$];
    logic [W-1:0] exp_q[$];
    int           total = 0;
    int           bad   = 0;
    int           n_cap, n_sh, n_pau, n_upd, n_oe;

    function automatic logic [W-1:0] sdr(input logic ds, input logic b);
        return {5'b00100, ds, 1'b1, b};
    endfunction

    function automatic logic [W-1:0] sir(input logic ds, input logic b);
        return {5'b00000, ds, 1'b1, b};
    endfunction

    function automatic logic [W-1:0] st(input logic [W-1:0] base, input logic ds);
        return base | {5'b0, ds, 2'b0};
    endfunction

    task automatic compare(input string name);
        logic [W-1:0] e, a;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            a = {tlr, cap, sh, pau, upd, dsel, tdo_oe, tdo};
            if (a !== e) begin
                bad++;
                $display("FAIL %s: got %b expected %b", name, a, e);
            end
        end
    endtask

    task automatic chk_count(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clr_counts();
        n_cap = 0; n_sh = 0; n_pau = 0; n_upd = 0; n_oe = 0;
    endtask

    // One TCK cycle: drive, push expectation, check #1 after the following negedge.
    task automatic step(input logic t, input logic d, input logic dd,
                        input logic [W-1:0] e, input string name);
        tms  = t;
        tdi  = d;
        dtdo = dd;
        exp_q.push_back(e);
        @(posedge tck);
        @(negedge tck);
        #1;
        compare(name);
        n_cap += int'(cap);
        n_sh  += int'(sh);
        n_pau += int'(pau);
        n_upd += int'(upd);
        n_oe  += int'(tdo_oe);
    endtask

    task automatic async_reset(input string name);
        #1;
        trstn = 1'b0;
        tms   = 1'b1;
        exp_q.push_back(E_TLR);
        #1;
        compare(name);
        @(posedge tck);
        @(negedge tck);
        #1;
        trstn = 1'b1;
    endtask

    // From Run-Test/Idle: read n IDCODE bits, return to Run-Test/Idle.
    task automatic read_idcode(input int n, input string name);
        logic [31:0] id;
        id = IDC;
        clr_counts();
        step(1, 0, 0, E_IDLE, {name, "_seldr"});
        step(0, 0, 0, E_CAP, {name, "_cap"});
        step(0, 0, 0, sdr(0, id[0]), {name, "_bit"});
        for (int i = 1; i < n; i++)
            step(0, 1'($urandom_range(0, 1)), 0, sdr(0, id[i]), {name, "_bit"});
        step(1, 0, 0, E_IDLE, {name, "_exit1"});
        step(1, 0, 0, E_UPD, {name, "_upd"});
        step(0, 0, 0, E_IDLE, {name, "_idle"});
        chk_count({name, "_oe_cycles"}, n_oe, n);
    endtask

    // From Run-Test/Idle: load a 4-bit instruction LSB-first and check the captured 0001.
    task automatic load_ir(input logic [3:0] v, input logic ds);
        step(1, 0, 0, st(E_IDLE, ds), "ir_seldr");
        step(1, 0, 0, st(E_IDLE, ds), "ir_selir");
        step(0, 0, 0, st(E_IDLE, ds), "ir_cap");
        step(0, 0, 0, sir(ds, 1'b1), "ir_tdo0");
        for (int i = 0; i < 4; i++)
            step((i == 3), v[i], 0, (i < 3) ? sir(ds, 1'b0) : st(E_IDLE, ds), "ir_tdo");
        step(1, 0, 0, st(E_IDLE, ds), "ir_upd");
        step(0, 0, 0, st(E_IDLE, (v == 4'b1000)), "ir_active");
    endtask

    initial begin
        logic       dd;
        logic [7:0] bp;

        // TMS walk from TLR through every DR state, into IR, then a soft reset from Pause-IR.
        vecs.push_back('{1'b1, 1'b0, E_TLR});
        vecs.push_back('{1'b0, 1'b0, E_IDLE});
        vecs.push_back('{1'b0, 1'b0, E_IDLE});
        vecs.push_back('{1'b1, 1'b0, E_IDLE});
        vecs.push_back('{1'b0, 1'b0, E_CAP});
        vecs.push_back('{1'b0, 1'b1, sdr(0, 1'b1)});
        vecs.push_back('{1'b0, 1'b0, sdr(0, 1'b0)});
        vecs.push_back('{1'b1, 1'b0, E_IDLE});
        vecs.push_back('{1'b0, 1'b0, E_PAU});
        vecs.push_back('{1'b0, 1'b0, E_PAU});
        vecs.push_back('{1'b1, 1'b0, E_IDLE});
        vecs.push_back('{1'b1, 1'b0, E_UPD});
        vecs.push_back('{1'b1, 1'b0, E_IDLE});
        vecs.push_back('{1'b1, 1'b0, E_IDLE});
        vecs.push_back('{1'b0, 1'b0, E_IDLE});
        vecs.push_back('{1'b0, 1'b0, sir(0, 1'b1)});
        vecs.push_back('{1'b1, 1'b0, E_IDLE});
        vecs.push_back('{1'b0, 1'b0, E_IDLE});
        vecs.push_back('{1'b1, 1'b0, E_IDLE});
        vecs.push_back('{1'b1, 1'b0, E_IDLE});
        vecs.push_back('{1'b1, 1'b0, E_IDLE});
        vecs.push_back('{1'b1, 1'b0, E_IDLE});
        vecs.push_back('{1'b1, 1'b0, E_TLR});
        vecs.push_back('{1'b1, 1'b0, E_TLR});

        #2;
        trstn = 1'b0;
        @(negedge tck);
        #1;
        exp_q.push_back(E_TLR);
        compare("reset_state");
        @(posedge tck);
        @(negedge tck);
        #1;
        trstn = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].tms, vecs[i].tdi, 1'b0, vecs[i].exp, $sformatf("walk_%0d", i));

        step(0, 0, 0, E_IDLE, "to_idle");
        read_idcode(32, "idcode");

        load_ir(4'b1000, 1'b0);

        // DEBUG scan: Capture, Shift x64, Exit1, Pause x3, Exit2, Shift x2, Exit1, Update.
        clr_counts();
        step(1, 0, 0, st(E_IDLE, 1), "dbg_seldr");
        step(0, 0, 0, st(E_CAP, 1), "dbg_cap");
        dd = 1'($urandom_range(0, 1));
        step(0, 0, dd, sdr(1, dd), "dbg_shift");
        for (int i = 1; i < 64; i++) begin
            dd = 1'($urandom_range(0, 1));
            step(0, 1'($urandom_range(0, 1)), dd, sdr(1, dd), "dbg_shift");
        end
        step(1, 0, 0, st(E_IDLE, 1), "dbg_exit1");
        for (int i = 0; i < 3; i++) step(0, 0, 0, st(E_PAU, 1), "dbg_pause");
        step(1, 0, 0, st(E_IDLE, 1), "dbg_exit2");
        for (int i = 0; i < 2; i++) begin
            dd = 1'($urandom_range(0, 1));
            step(0, 0, dd, sdr(1, dd), "dbg_shift2");
        end
        step(1, 0, 0, st(E_IDLE, 1), "dbg_exit1b");
        step(1, 0, 0, st(E_UPD, 1), "dbg_upd");
        step(0, 0, 0, st(E_IDLE, 1), "dbg_idle");
        chk_count("dbg_capture_cycles", n_cap, 1);
        chk_count("dbg_shift_cycles", n_sh, 66);
        chk_count("dbg_pause_cycles", n_pau, 3);
        chk_count("dbg_update_cycles", n_upd, 1);

        // BYPASS: the 8 input bits come back one TCK later behind the captured 0.
        load_ir(4'b1111, 1'b1);
        bp = 8'b10110011;
        step(1, 0, 0, E_IDLE, "byp_seldr");
        step(0, 0, 0, E_CAP, "byp_cap");
        step(0, 0, 0, sdr(0, 1'b0), "byp_first");
        for (int k = 0; k < 8; k++)
            step((k == 7), bp[7-k], 0, (k < 7) ? sdr(0, bp[7-k]) : E_IDLE, "byp_bit");
        step(1, 0, 0, E_UPD, "byp_upd");
        step(0, 0, 0, E_IDLE, "byp_idle");

        // Asynchronous reset in the middle of a DEBUG Shift-DR.
        load_ir(4'b1000, 1'b0);
        step(1, 0, 0, st(E_IDLE, 1), "rst_dr_seldr");
        step(0, 0, 0, st(E_CAP, 1), "rst_dr_cap");
        for (int i = 0; i < 4; i++) step(0, 1, 1, sdr(1, 1'b1), "rst_dr_shift");
        async_reset("reset_mid_shift_dr");
        step(0, 0, 0, E_IDLE, "rst_dr_idle");
        read_idcode(32, "rst_dr_idcode");

        // Asynchronous reset in the middle of Shift-IR discards the partial instruction.
        step(1, 0, 0, E_IDLE, "rst_ir_seldr");
        step(1, 0, 0, E_IDLE, "rst_ir_selir");
        step(0, 0, 0, E_IDLE, "rst_ir_cap");
        step(0, 0, 0, sir(0, 1'b1), "rst_ir_tdo0");
        step(0, 0, 0, sir(0, 1'b0), "rst_ir_tdo1");
        step(0, 0, 0, sir(0, 1'b0), "rst_ir_tdo2");
        async_reset("reset_mid_shift_ir");
        step(0, 0, 0, E_IDLE, "rst_ir_idle");
        read_idcode(8, "rst_ir_idcode");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
